// File: rtl/exp4_gravador_sequencia_pkg.sv
// exp4_gravador_sequencia_pkg: shared geometry, FSM state codes and one-hot helper
package exp4_gravador_sequencia_pkg;
  localparam int PROFUNDIDADE = 16;
  localparam int ENDERECO = 4;
  localparam int LARGURA = 4;
  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    ESPERA   = 4'd2,
    REGISTRA = 4'd3,
    SOLTAR   = 4'd4,
    FIM      = 4'd15
  } estado_t;
  function automatic logic one_hot(input logic [LARGURA-1:0] v);
    return $countones(v) == 1;
  endfunction
endpackage

// File: rtl/exp4_gravador_sequencia_if.sv
// exp4_gravador_sequencia_if: key/control inputs, read port and status of the recorder
interface exp4_gravador_sequencia_if
  import exp4_gravador_sequencia_pkg::*;
#(
  parameter int ENDERECO_P = ENDERECO,
  parameter int LARGURA_P = LARGURA
);
  logic iniciar;
  logic terminar;
  logic [LARGURA_P-1:0] chaves;
  logic [ENDERECO_P-1:0] leitura_endereco;
  logic [LARGURA_P-1:0] leitura_dado;
  logic gravando;
  logic pronto;
  logic erro_jogada;
  logic [ENDERECO_P:0] total;
  logic [ENDERECO_P-1:0] db_endereco;
  logic [3:0] db_estado;
  modport master (
    output iniciar, terminar, chaves, leitura_endereco,
    input leitura_dado, gravando, pronto, erro_jogada, total, db_endereco, db_estado
  );
  modport slave (
    input iniciar, terminar, chaves, leitura_endereco,
    output leitura_dado, gravando, pronto, erro_jogada, total, db_endereco, db_estado
  );
endinterface

// File: rtl/exp4_gravador_sequencia_sync_ram_16x4.sv
// sync_ram_16x4: one write port, registered read port, read-before-write
module sync_ram_16x4 #(
  parameter int PROFUNDIDADE = 16,
  parameter int ENDERECO = 4,
  parameter int LARGURA = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic we,
  input  logic [ENDERECO-1:0] waddr,
  input  logic [LARGURA-1:0] wdata,
  input  logic [ENDERECO-1:0] raddr,
  output logic [LARGURA-1:0] rdata
);
  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/exp4_gravador_sequencia.sv
// exp4_gravador_sequencia: records one-hot key presses into a RAM read by the checker
module exp4_gravador_sequencia
  import exp4_gravador_sequencia_pkg::*;
(
  input logic clock,
  input logic reset_n,
  exp4_gravador_sequencia_if.slave bus
);
  estado_t estado, proximo;
  logic [LARGURA-1:0] s_jogada;
  logic [ENDERECO-1:0] endereco;
  logic [ENDERECO:0] total;
  logic valida, escreve;
  assign valida = one_hot(s_jogada);
  assign escreve = estado == REGISTRA && valida && total < (ENDERECO+1)'(PROFUNDIDADE);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado <= INICIAL;
      s_jogada <= '0;
      endereco <= '0;
      total <= '0;
    end else begin
      estado <= proximo;
      if (estado == PREPARA) begin
        endereco <= '0;
        total <= '0;
      end
      if (estado == ESPERA && !bus.terminar && bus.chaves != '0) s_jogada <= bus.chaves;
      if (escreve) begin
        endereco <= endereco + ENDERECO'(1);
        total <= total + (ENDERECO+1)'(1);
      end
    end
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:  proximo = bus.iniciar ? PREPARA : INICIAL;
      PREPARA:  proximo = ESPERA;
      ESPERA:   proximo = bus.terminar ? FIM : bus.chaves != '0 ? REGISTRA : ESPERA;
      REGISTRA: proximo = escreve && total == (ENDERECO+1)'(PROFUNDIDADE-1) ? FIM : SOLTAR;
      SOLTAR:   proximo = bus.chaves == '0 ? ESPERA : SOLTAR;
      FIM:      proximo = bus.iniciar ? PREPARA : FIM;
      default:  proximo = INICIAL;
    endcase
  end
  sync_ram_16x4 #(.PROFUNDIDADE(PROFUNDIDADE), .ENDERECO(ENDERECO), .LARGURA(LARGURA)) u_ram (
    .clock(clock),
    .reset_n(reset_n),
    .we(escreve),
    .waddr(endereco),
    .wdata(s_jogada),
    .raddr(bus.leitura_endereco),
    .rdata(bus.leitura_dado)
  );
  assign bus.gravando = estado inside {ESPERA, REGISTRA, SOLTAR};
  assign bus.pronto = estado == FIM;
  assign bus.erro_jogada = estado == REGISTRA && !valida;
  assign bus.total = total;
  assign bus.db_endereco = endereco;
  assign bus.db_estado = estado;
endmodule
